// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Sweeps all eight input combinations of a 3-input gate under test and
// compares each response against the expected NAND value.
// Each vector is held for SETTLE_CYCLES settling cycles and is then sampled
// for one cycle.
// The sweep's verdict is reported with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request one full sweep; only accepted while idle
//   y_in       response of the gate under test
//   abc_out    vector driven to the gate (bit2=a, bit1=b, bit0=c)
//   busy       high while a sweep is in progress
//   done       one-cycle pulse at sweep completion
//   pass       last completed sweep had no mismatches
//   err_count  number of mismatching vectors in the last sweep (0..8)
//   fail_vec   bit i set when vector i mismatched in the last sweep
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic [2:0] abc_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  // With no settling time a new vector goes straight to sampling, so the
  // settle state is never entered.
  localparam bit         SKIP_SETTLE  = (SETTLE_CYCLES == 0);
  localparam logic [7:0] SETTLE_LAST  = SKIP_SETTLE ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam state_t     VECTOR_ENTRY = SKIP_SETTLE ? SAMPLE : SETTLE;

  state_t     state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [2:0] abc_d;
  logic       busy_d;
  logic       done_d;
  logic       pass_d;
  logic [3:0] err_d;
  logic [7:0] fail_d;
  logic       mismatch;

  // All outputs are flops.
  // This block computes their next values together with the next state.
  // As a result, y_in and start only ever reach an output through a register.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    abc_d        = abc_out;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_d        = err_count;
    fail_d       = fail_vec;
    mismatch     = 1'b0;

    case (state_q)
      IDLE: begin
        abc_d  = 3'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d      = VECTOR_ENTRY;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_d        = 4'd0;
          fail_d       = 8'd0;
          settle_cnt_d = 8'd0;
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = SAMPLE;
          settle_cnt_d = 8'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end

      SAMPLE: begin
        // The gate under test should behave as a 3-input NAND.
        mismatch = (y_in != ~&abc_out);
        if (mismatch) begin
          fail_d[abc_out] = 1'b1;
          if (err_count != 4'd8) begin
            err_d = err_count + 4'd1;
          end
        end
        if (abc_out == 3'd7) begin
          state_d = FINISH;
          abc_d   = 3'd0;
          busy_d  = 1'b0;
        end else begin
          state_d      = VECTOR_ENTRY;
          abc_d        = abc_out + 3'd1;
          settle_cnt_d = 8'd0;
        end
      end

      FINISH: begin
        // err_count already includes the last vector's result here.
        done_d  = 1'b1;
        pass_d  = (err_count == 4'd0);
        abc_d   = 3'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The state register and every registered output.
  // Reset clears everything immediately.
  // This includes the last sweep's verdict and any sweep in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= 8'd0;
      abc_out      <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= 4'd0;
      fail_vec     <= 8'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      abc_out      <= abc_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
      err_count    <= err_d;
      fail_vec     <= fail_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer
// Self-checking bench with two sequencer instances:
//   dut   uses the default settle time
//   dut0  uses SETTLE_CYCLES=0
//
// Each instance drives a modelled gate.
// The modelled gate is a NAND whose response is inverted on the vectors
// selected by a fault mask.
// From that mask, the expected verdict follows directly:
//   fail_vec equals the mask
//   err_count is the number of bits set in the mask
//   pass holds when the mask is zero
// The expected vector on each cycle is computed from the elapsed cycle count.
module tb_truth_table_sequencer;

  localparam int S     = 4;
  localparam int P     = S + 1;
  localparam int SWEEP = 8 * P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start0;
  logic [7:0] cur_mask;

  logic       y_in;
  logic [2:0] abc_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  logic       y_in0;
  logic [2:0] abc_out0;
  logic       busy0;
  logic       done0;
  logic       pass0;
  logic [3:0] err_count0;
  logic [7:0] fail_vec0;

  int checks = 0;
  int errors = 0;

  // Faulty-gate models: a NAND whose response is flipped on masked vectors.
  assign y_in  = (~&abc_out)  ^ cur_mask[abc_out];
  assign y_in0 = (~&abc_out0) ^ cur_mask[abc_out0];

  always #5 clk = ~clk;

  truth_table_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .y_in      (y_in),
    .abc_out   (abc_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .y_in      (y_in0),
    .abc_out   (abc_out0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err_count0),
    .fail_vec  (fail_vec0)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Confirms that every output of both instances is zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_abc"},   32'(abc_out),    0);
    checkOutput({tag, "_busy"},  32'(busy),       0);
    checkOutput({tag, "_done"},  32'(done),       0);
    checkOutput({tag, "_pass"},  32'(pass),       0);
    checkOutput({tag, "_err"},   32'(err_count),  0);
    checkOutput({tag, "_fail"},  32'(fail_vec),   0);
    checkOutput({tag, "_abc0"},  32'(abc_out0),   0);
    checkOutput({tag, "_busy0"}, 32'(busy0),      0);
    checkOutput({tag, "_done0"}, 32'(done0),      0);
    checkOutput({tag, "_pass0"}, 32'(pass0),      0);
    checkOutput({tag, "_err0"},  32'(err_count0), 0);
    checkOutput({tag, "_fail0"}, 32'(fail_vec0),  0);
  endtask

  // Runs one sweep on both instances with the given fault mask.
  // j counts edges after the accepting edge; outputs are checked at the
  // falling edge that follows each edge.
  // extra: re-pulse start on the main instance while it is busy and during
  //        its FINISH cycle.
  // abort_at >= 0: assert reset at that point instead of finishing.
  task automatic applyStimulus(input logic [7:0] mask, input bit extra,
                               input int abort_at);
    int exp_err;
    exp_err  = $countones(mask);
    cur_mask = mask;
    @(negedge clk);
    start  = 1'b1;
    start0 = 1'b1;
    for (int j = 0; j <= SWEEP + 4; j++) begin
      @(negedge clk);
      start0 = 1'b0;
      start  = extra && (j == 4 || j == 19 || j == SWEEP);
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        #1 checkAllZero("abort");
        repeat (3) begin
          @(negedge clk);
          checkOutput("abort_done", 32'(done), 0);
          checkOutput("abort_busy", 32'(busy), 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        return;
      end

      checkOutput("abc",  32'(abc_out), (j < SWEEP) ? j / P : 0);
      checkOutput("busy", 32'(busy),    (j < SWEEP) ? 1 : 0);
      checkOutput("done", 32'(done),    (j == SWEEP + 1) ? 1 : 0);
      if (j == 0) begin
        checkOutput("clr_pass", 32'(pass),      0);
        checkOutput("clr_err",  32'(err_count), 0);
        checkOutput("clr_fail", 32'(fail_vec),  0);
      end
      if (j >= SWEEP + 1) begin
        checkOutput("pass", 32'(pass),      (mask == 8'd0) ? 1 : 0);
        checkOutput("err",  32'(err_count), exp_err);
        checkOutput("fail", 32'(fail_vec),  32'(mask));
      end

      checkOutput("abc0",  32'(abc_out0), (j < 8) ? j : 0);
      checkOutput("busy0", 32'(busy0),    (j < 8) ? 1 : 0);
      checkOutput("done0", 32'(done0),    (j == 9) ? 1 : 0);
      if (j >= 9) begin
        checkOutput("pass0", 32'(pass0),      (mask == 8'd0) ? 1 : 0);
        checkOutput("err0",  32'(err_count0), exp_err);
        checkOutput("fail0", 32'(fail_vec0),  32'(mask));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    start0   = 1'b0;
    cur_mask = 8'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Directed sweeps with the fault masks listed below.
    applyStimulus(8'h00, 1'b1, -1);   // correct gate, with ignored starts
    applyStimulus(8'h80, 1'b0, -1);   // output stuck at 1
    applyStimulus(8'h7F, 1'b0, -1);   // output stuck at 0
    applyStimulus(8'hFF, 1'b1, -1);   // AND instead of NAND
    applyStimulus(8'h5A, 1'b0, 15);   // reset mid-sweep
    applyStimulus(8'h00, 1'b0, -1);   // clean sweep after the abort

    // Random fault patterns.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
